// File: rtl/rbm_pkg.sv
// Shared data format, LFSR polynomial, state encodings and the saturate/sigmoid/LFSR helpers
// used by the RBM classifier datapath.
package rbm_pkg;

  localparam int DATA_W    = 12;
  localparam int FRAC_BITS = 6;
  localparam int ACC_WIDTH = 24;
  localparam int PROB_W    = 8;

  localparam logic [DATA_W-1:0] INF = 12'h7FF;
  // x^8+x^6+x^5+x^4+1, shifted left with feedback from bits 7,5,4,3
  localparam logic [PROB_W-1:0] LFSR_TAPS = 8'b1011_1000;

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI   = {{(ACC_WIDTH-DATA_W){1'b0}}, INF};
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO   = -SAT_HI;
  localparam logic signed [DATA_W:0]      SIG_BIAS = 13'sd128;
  localparam logic signed [DATA_W:0]      SIG_MAX  = 13'sd255;

`ifdef SPARSE
  localparam bit SPARSE_BUILD = 1'b1;
`else
  localparam bit SPARSE_BUILD = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, HIDDEN, CLASS, NEXT, DONE} rbm_state_e;
  typedef enum logic [1:0] {LAYER_IDLE, LAYER_BIAS, LAYER_MAC, LAYER_SAMPLE} layer_phase_e;

  function automatic int in_dim(input int g_dim, input int s_dim);
    return SPARSE_BUILD ? s_dim : g_dim;
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_WIDTH-1:0] acc);
    if (acc > SAT_HI) return INF;
    if (acc < SAT_LO) return DATA_W'(SAT_LO);
    return acc[DATA_W-1:0];
  endfunction

  function automatic logic [PROB_W-1:0] sigmoid(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W:0] t;
    t = (DATA_W+1)'(v) + SIG_BIAS;
    if (t[DATA_W]) return '0;
    if (t > SIG_MAX) return '1;
    return t[PROB_W-1:0];
  endfunction

  function automatic logic [PROB_W-1:0] lfsr_next(input logic [PROB_W-1:0] s);
    return {s[PROB_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [PROB_W-1:0] lfsr_seed(input logic [PROB_W-1:0] s);
    return (s == '0) ? PROB_W'(1) : s;
  endfunction

endpackage

// File: rtl/rbm_neuron_layer.sv
// One stochastic neuron layer: LANES neurons accumulate one input term per cycle, then each
// saturated sum goes through the sigmoid and is compared with that neuron's LFSR to give a bit.
module rbm_neuron_layer
  import rbm_pkg::*;
#(
  parameter int IN_DIM  = 2,
  parameter int OUT_DIM = 2,
  parameter int LANES   = 1,
  parameter int XW      = DATA_W,
  parameter logic [IN_DIM*OUT_DIM*DATA_W-1:0] W_INIT = '0,
  parameter logic [OUT_DIM*DATA_W-1:0]        B_INIT = '0,
  parameter logic [OUT_DIM*PROB_W-1:0]        S_INIT = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [IN_DIM*XW-1:0] x_i,
  output logic [OUT_DIM-1:0]   fire_o,
  output logic                 done_o
);

  localparam int NGRP = (OUT_DIM + LANES - 1) / LANES;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int IXW  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;

  layer_phase_e                  phase_q;
  logic [GW-1:0]                 grp_q;
  logic [IXW-1:0]                idx_q;
  logic signed [ACC_WIDTH-1:0]   acc_q [LANES];
  logic [PROB_W-1:0]             lfsr_q [OUT_DIM];
  logic [OUT_DIM-1:0]            fire_q;
  logic                          done_q;

  logic [XW-1:0]                 xw;
  logic signed [ACC_WIDTH-1:0]   term [LANES];
  logic signed [ACC_WIDTH-1:0]   bias_w [LANES];

  function automatic int lane_neuron(input logic [GW-1:0] g, input int l);
    return int'(g) * LANES + l;
  endfunction

  function automatic logic signed [DATA_W-1:0] weight_at(input int i, input int n);
    return $signed(W_INIT[(i*OUT_DIM + n)*DATA_W +: DATA_W]);
  endfunction

  // A 1-bit input is a sampled hidden unit: it gates the raw weight instead of scaling it.
  always_comb begin
    xw = x_i[int'(idx_q)*XW +: XW];
    for (int l = 0; l < LANES; l++) begin
      term[l]   = '0;
      bias_w[l] = '0;
      if (lane_neuron(grp_q, l) < OUT_DIM) begin
        bias_w[l] = ACC_WIDTH'($signed(B_INIT[lane_neuron(grp_q, l)*DATA_W +: DATA_W]));
        if (XW == 1)
          term[l] = xw[0] ? ACC_WIDTH'(weight_at(int'(idx_q), lane_neuron(grp_q, l))) : '0;
        else
          term[l] = (ACC_WIDTH'($signed(xw)) *
                     ACC_WIDTH'(weight_at(int'(idx_q), lane_neuron(grp_q, l)))) >>> FRAC_BITS;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= LAYER_IDLE;
      grp_q   <= '0;
      idx_q   <= '0;
      fire_q  <= '0;
      done_q  <= 1'b0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
      for (int n = 0; n < OUT_DIM; n++) lfsr_q[n] <= lfsr_seed(S_INIT[n*PROB_W +: PROB_W]);
    end else begin
      done_q <= 1'b0;
      case (phase_q)
        LAYER_IDLE: if (start_i) begin
          grp_q   <= '0;
          phase_q <= LAYER_BIAS;
        end
        LAYER_BIAS: begin
          for (int l = 0; l < LANES; l++) acc_q[l] <= bias_w[l];
          idx_q   <= '0;
          phase_q <= LAYER_MAC;
        end
        LAYER_MAC: begin
          for (int l = 0; l < LANES; l++) acc_q[l] <= acc_q[l] + term[l];
          if (idx_q == IXW'(IN_DIM - 1)) phase_q <= LAYER_SAMPLE;
          else                           idx_q   <= idx_q + 1'b1;
        end
        LAYER_SAMPLE: begin
          for (int n = 0; n < OUT_DIM; n++) begin
            if (GW'(n / LANES) == grp_q) begin
              fire_q[n] <= (lfsr_q[n] <= sigmoid(saturate(acc_q[n % LANES])));
              lfsr_q[n] <= lfsr_next(lfsr_q[n]);
            end
          end
          if (grp_q == GW'(NGRP - 1)) begin
            phase_q <= LAYER_IDLE;
            done_q  <= 1'b1;
          end else begin
            grp_q   <= grp_q + 1'b1;
            phase_q <= LAYER_BIAS;
          end
        end
        default: phase_q <= LAYER_IDLE;
      endcase
    end
  end

  assign fire_o = fire_q;
  assign done_o = done_q;

endmodule

// File: rtl/rbm_classifier_main.sv
// Stochastic RBM classifier: per iteration sample hidden then class layer, count class firings,
// raise finish after iteration_num iterations. Weight/bias/seed images arrive as parameters.
module rbm_classifier_main
  import rbm_pkg::*;
#(
  parameter int bitlength              = DATA_W,
  parameter int sigmoid_bitlength      = PROB_W,
  parameter int general_input_dim      = 784,
  parameter int sparse_input_dim       = 64,
  parameter int hidden_dim             = 441,
  parameter int output_dim             = 10,
  parameter int hidden_adder_group_num = 1,
  parameter int cl_adder_group_num     = 1,
  parameter int iteration_num          = 40,
  parameter logic [in_dim(general_input_dim, sparse_input_dim)*hidden_dim*bitlength-1:0] h_weight = '0,
  parameter logic [hidden_dim*bitlength-1:0]            h_bias   = '0,
  parameter logic [hidden_dim*sigmoid_bitlength-1:0]    h_seed   = '0,
  parameter logic [hidden_dim*output_dim*bitlength-1:0] c_weight = '0,
  parameter logic [output_dim*bitlength-1:0]            c_bias   = '0,
  parameter logic [output_dim*sigmoid_bitlength-1:0]    c_seed   = '0
) (
  input  logic                                                             clock,
  input  logic                                                             reset,
  input  logic                                                             data_valid,
  input  logic [in_dim(general_input_dim, sparse_input_dim)*bitlength-1:0] InputDataPort,
  output logic [output_dim*bitlength-1:0]                                  OutputDataPort,
  output logic                                                             finish
);

  localparam int input_dim = in_dim(general_input_dim, sparse_input_dim);
  localparam int IW        = $clog2(iteration_num + 1);

  rbm_state_e                     state_q;
  logic [input_dim*bitlength-1:0] x_q;
  logic [IW-1:0]                  iter_q;
  logic [DATA_W-1:0]              count_q [output_dim];
  logic                           finish_q, h_start_q, c_start_q;

  logic [hidden_dim-1:0] h_fire;
  logic [output_dim-1:0] c_fire;
  logic                  h_done, c_done;

  rbm_neuron_layer #(
    .IN_DIM(input_dim), .OUT_DIM(hidden_dim), .LANES(hidden_adder_group_num), .XW(bitlength),
    .W_INIT(h_weight), .B_INIT(h_bias), .S_INIT(h_seed)
  ) u_hidden (
    .clock(clock), .reset(reset), .start_i(h_start_q), .x_i(x_q),
    .fire_o(h_fire), .done_o(h_done)
  );

  rbm_neuron_layer #(
    .IN_DIM(hidden_dim), .OUT_DIM(output_dim), .LANES(cl_adder_group_num), .XW(1),
    .W_INIT(c_weight), .B_INIT(c_bias), .S_INIT(c_seed)
  ) u_class (
    .clock(clock), .reset(reset), .start_i(c_start_q), .x_i(h_fire),
    .fire_o(c_fire), .done_o(c_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      iter_q    <= '0;
      finish_q  <= 1'b0;
      h_start_q <= 1'b0;
      c_start_q <= 1'b0;
      for (int k = 0; k < output_dim; k++) count_q[k] <= '0;
    end else begin
      h_start_q <= 1'b0;
      c_start_q <= 1'b0;
      case (state_q)
        IDLE: if (data_valid) begin
          x_q       <= InputDataPort;
          iter_q    <= '0;
          h_start_q <= 1'b1;
          state_q   <= HIDDEN;
          for (int k = 0; k < output_dim; k++) count_q[k] <= '0;
        end
        HIDDEN: if (h_done) begin
          c_start_q <= 1'b1;
          state_q   <= CLASS;
        end
        CLASS: if (c_done) begin
          for (int k = 0; k < output_dim; k++)
            if (c_fire[k] && count_q[k] != INF) count_q[k] <= count_q[k] + 1'b1;
          state_q <= NEXT;
        end
        NEXT: begin
          iter_q <= iter_q + 1'b1;
          if (iter_q == IW'(iteration_num - 1)) begin
            finish_q <= 1'b1;
            state_q  <= DONE;
          end else begin
            h_start_q <= 1'b1;
            state_q   <= HIDDEN;
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Counts are only exposed once a run has completed.
  always_comb begin
    OutputDataPort = '0;
    for (int k = 0; k < output_dim; k++)
      OutputDataPort[k*bitlength +: bitlength] = finish_q ? count_q[k] : '0;
  end

  assign finish = finish_q;

endmodule

// File: tb/tb_rbm_classifier_main.sv
// Directed bench: four small classifier builds with hand-computed results, covering reset,
// deterministic and stochastic class outputs, DONE hold, mid-run reset and count saturation.
module tb_rbm_classifier_main;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, dv;
  logic [23:0] x;
  logic [23:0] out_a, out_b, out_c, out_d;
  logic        fin_a, fin_b, fin_c, fin_d;
  int          errs = 0;
  int          checks = 0;

  // a: all biases -Inf -> nothing fires
  rbm_classifier_main #(
    .general_input_dim(2), .hidden_dim(2), .output_dim(2), .iteration_num(40),
    .h_weight('0), .h_bias(24'h801_801), .h_seed(16'h3C_A5),
    .c_weight('0), .c_bias(24'h801_801), .c_seed(16'h91_17)
  ) dut_a (
    .clock(clk), .reset(rst_a), .data_valid(dv), .InputDataPort(x),
    .OutputDataPort(out_a), .finish(fin_a)
  );

  // b: class biases {+Inf, -Inf}
  rbm_classifier_main #(
    .general_input_dim(2), .hidden_dim(2), .output_dim(2), .iteration_num(40),
    .h_weight('0), .h_bias('0), .h_seed(16'h3C_A5),
    .c_weight('0), .c_bias(24'h801_7FF), .c_seed(16'h91_17)
  ) dut_b (
    .clock(clk), .reset(rst_b), .data_valid(dv), .InputDataPort(x),
    .OutputDataPort(out_b), .finish(fin_b)
  );

  // c: as b but two lanes per layer and enough iterations to saturate
  rbm_classifier_main #(
    .general_input_dim(2), .hidden_dim(2), .output_dim(2), .iteration_num(2100),
    .hidden_adder_group_num(2), .cl_adder_group_num(2),
    .h_weight('0), .h_bias('0), .h_seed(16'h3C_A5),
    .c_weight('0), .c_bias(24'h801_7FF), .c_seed(16'h91_17)
  ) dut_c (
    .clock(clk), .reset(rst_a), .data_valid(dv), .InputDataPort(x),
    .OutputDataPort(out_c), .finish(fin_c)
  );

  // d: x={-2.0,1.0}; h0 acc=200, h1 acc=-1000+2000=1000 -> both always fire;
  // class0 -2047+2047+2047 always fires; class1 acc 0 -> s=128, zero seed becomes 1
  rbm_classifier_main #(
    .general_input_dim(2), .hidden_dim(2), .output_dim(2), .iteration_num(40),
    .h_weight(48'hC18_000_C18_0C8), .h_bias('0), .h_seed(16'h6D_B2),
    .c_weight(48'h000_7FF_000_7FF), .c_bias(24'h000_801), .c_seed(16'h00_5A)
  ) dut_d (
    .clock(clk), .reset(rst_b), .data_valid(dv), .InputDataPort(x),
    .OutputDataPort(out_d), .finish(fin_d)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic fin_sel(input int sel);
    case (sel)
      0:       return fin_a;
      1:       return fin_b;
      2:       return fin_c;
      default: return fin_d;
    endcase
  endfunction

  task automatic wait_fin(input int sel, input int budget, input string tag);
    int n = 0;
    while (fin_sel(sel) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(fin_sel(sel)), 32'd1);
  endtask

  // Independent LFSR model: how many of the first n states (from seed) are <= thr.
  function automatic int count_le(input logic [7:0] seed, input int n, input int thr);
    logic [7:0] s;
    int c;
    s = (seed == 8'd0) ? 8'd1 : seed;
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (int'(s) <= thr) c++;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    return c;
  endfunction

  task automatic start_pulse();
    @(negedge clk);
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
  endtask

  initial begin
    logic [23:0] exp_d;
    exp_d = {12'(count_le(8'h00, 40, 128)), 12'd40};
    rst_a = 1'b0;
    rst_b = 1'b0;
    dv    = 1'b0;
    x     = 24'hF80040;
    repeat (2) @(negedge clk);
    chk("reset_fin_a", 32'(fin_a), 32'd0);
    chk("reset_fin_c", 32'(fin_c), 32'd0);
    chk("reset_out_b", 32'(out_b), 32'd0);
    chk("reset_out_d", 32'(out_d), 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    start_pulse();
    x = 24'h000000;
    repeat (100) @(negedge clk);
    chk("midrun_fin_d", 32'(fin_d), 32'd0);
    chk("midrun_out_d", 32'(out_d), 32'd0);

    wait_fin(0, 3000, "finish_a");
    chk("out_a", 32'(out_a), 32'd0);
    wait_fin(1, 3000, "finish_b");
    chk("out_b", 32'(out_b), 32'h000028);
    wait_fin(3, 3000, "finish_d");
    chk("out_d", 32'(out_d), 32'(exp_d));

    x  = 24'hF80040;
    dv = 1'b1;
    repeat (3) @(negedge clk);
    dv = 1'b0;
    repeat (50) @(negedge clk);
    chk("done_hold_fin_a", 32'(fin_a), 32'd1);
    chk("done_hold_out_b", 32'(out_b), 32'h000028);
    chk("done_hold_out_d", 32'(out_d), 32'(exp_d));

    rst_b = 1'b0;
    #1;
    chk("async_reset_fin_b", 32'(fin_b), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    start_pulse();
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_fin_b", 32'(fin_b), 32'd0);
    chk("abort_out_d", 32'(out_d), 32'd0);
    rst_b = 1'b1;

    start_pulse();
    x = 24'h000000;
    repeat (200) @(negedge clk);
    chk("rerun_mid_fin_b", 32'(fin_b), 32'd0);
    wait_fin(1, 3000, "rerun_finish_b");
    chk("rerun_out_b", 32'(out_b), 32'h000028);
    wait_fin(3, 3000, "rerun_finish_d");
    chk("rerun_out_d", 32'(out_d), 32'(exp_d));

    wait_fin(2, 40000, "finish_c");
    chk("sat_out_c", 32'(out_c), 32'h0007FF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
